digit_editor: RTL

//  Button-driven editor for the hex value shown on the seven-segment display.

---
 rtl/digit_editor_pkg.sv | 19 +
 rtl/digit_editor_hold_repeater.sv | 42 ++++
 rtl/digit_editor.sv | 136 +++++++++++++
 3 files changed

// File: rtl/digit_editor_pkg.sv
// Definitions shared by the digit editor and the seven-segment decoder:
// mode encoding, field widths and the wrapping digit step.
package digit_editor_pkg;

  typedef enum logic {
    ST_VIEW = 1'b0,
    ST_EDIT = 1'b1
  } editState_t;

  localparam int DIGIT_W  = 4;
  localparam int CURSOR_W = 3;

  // Hex digit +/-1; the 4-bit result wraps F->0 and 0->F on its own.
  function automatic logic [DIGIT_W-1:0] stepDigit(input logic [DIGIT_W-1:0] d,
                                                   input logic inc);
    return inc ? d + 1'b1 : d - 1'b1;
  endfunction

endpackage

// File: rtl/digit_editor_hold_repeater.sv
// Hold-to-repeat timer: after DELAY clocks of continuous hold, one pulse, then every RATE clocks.
// Only present in builds with AUTO_REPEAT_EN defined.
`ifdef AUTO_REPEAT_EN
module digit_editor_hold_repeater #(
  parameter int DELAY = 8,
  parameter int RATE  = 3
) (
  input  logic clk,
  input  logic rst,
  input  logic level,
  input  logic clear,
  output logic repeatPulse
);

  localparam int MAX_V = (DELAY > RATE) ? DELAY : RATE;
  localparam int CW    = $clog2(MAX_V + 1);

  logic          armed;
  logic [CW-1:0] cnt;

  // The press edge itself arms the timer, so the first repeat lands on hold clock DELAY.
  assign repeatPulse = armed && level && (cnt == '0);

  always_ff @(posedge clk) begin
    if (rst) begin
      armed <= 1'b0;
      cnt   <= '0;
    end else if (!level || clear) begin
      armed <= 1'b0;
      cnt   <= '0;
    end else if (!armed) begin
      armed <= 1'b1;
      cnt   <= CW'(DELAY - 2);
    end else if (cnt == '0) begin
      cnt <= CW'(RATE - 1);
    end else begin
      cnt <= cnt - 1'b1;
    end
  end

endmodule
`endif

// File: rtl/digit_editor.sv
// Button-driven hex digit editor with blinking cursor for the 7SD path.
// Optional hold-to-repeat for up/down is built when AUTO_REPEAT_EN is defined.
//
//   state   | meaning
//   ST_VIEW | digits shown steady, only center is acted on
//   ST_EDIT | cursor digit blinks, up/down/left/right edit the value
module digit_editor
  import digit_editor_pkg::*;
#(
  parameter int NUM_DIGITS   = 4,
  parameter int BLINK_DIV_W  = 24,
  parameter int REPEAT_DELAY = 50_000_000,
  parameter int REPEAT_RATE  = 10_000_000
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          up_pulse,
  input  logic                          down_pulse,
  input  logic                          left_pulse,
  input  logic                          right_pulse,
  input  logic                          center_pulse,
  input  logic                          up_held,
  input  logic                          down_held,
  output logic [DIGIT_W*NUM_DIGITS-1:0] digits_out,
  output logic [CURSOR_W-1:0]           cursor_out,
  output logic [NUM_DIGITS-1:0]         digit_en_mask,
  output logic                          edit_mode,
  output logic                          value_changed
);

  localparam logic [CURSOR_W-1:0] LAST_CURSOR = CURSOR_W'(NUM_DIGITS - 1);

  editState_t                    state, nextState;
  logic [BLINK_DIV_W-1:0]        blinkCnt, nextBlink;
  logic [DIGIT_W*NUM_DIGITS-1:0] nextDigits;
  logic [CURSOR_W-1:0]           nextCursor;
  logic [NUM_DIGITS-1:0]         nextMask;
  logic                          nextChanged;
  logic                          upRep, downRep, upReq, downReq;

`ifdef AUTO_REPEAT_EN
  logic upLevel, downLevel, repClear;

  // Holding both buttons counts as a release for both timers.
  assign upLevel   = up_held && !down_held && (state == ST_EDIT);
  assign downLevel = down_held && !up_held && (state == ST_EDIT);
  assign repClear  = center_pulse || left_pulse || right_pulse;

  digit_editor_hold_repeater #(.DELAY(REPEAT_DELAY), .RATE(REPEAT_RATE)) upRepeater (
    .clk        (clk),
    .rst        (rst),
    .level      (upLevel),
    .clear      (repClear),
    .repeatPulse(upRep)
  );

  digit_editor_hold_repeater #(.DELAY(REPEAT_DELAY), .RATE(REPEAT_RATE)) downRepeater (
    .clk        (clk),
    .rst        (rst),
    .level      (downLevel),
    .clear      (repClear),
    .repeatPulse(downRep)
  );
`else
  logic unusedRepeat;
  assign unusedRepeat = (^{up_held, down_held}) ^ (REPEAT_DELAY > 0) ^ (REPEAT_RATE > 0);
  assign upRep        = 1'b0;
  assign downRep      = 1'b0;
`endif

  assign upReq   = up_pulse || upRep;
  assign downReq = down_pulse || downRep;

  always_comb begin
    nextState   = state;
    nextDigits  = digits_out;
    nextCursor  = cursor_out;
    nextChanged = 1'b0;
    nextBlink   = (state == ST_EDIT) ? blinkCnt + 1'b1 : '0;

    if (center_pulse) begin
      nextBlink = '0;
      if (state == ST_EDIT) begin
        nextState = ST_VIEW;
      end else begin
        nextState  = ST_EDIT;
        nextCursor = '0;
      end
    end else if (state == ST_EDIT) begin
      if (upReq ^ downReq) begin
        for (int i = 0; i < NUM_DIGITS; i++) begin
          if (CURSOR_W'(i) == cursor_out)
            nextDigits[i*DIGIT_W +: DIGIT_W] = stepDigit(digits_out[i*DIGIT_W +: DIGIT_W], upReq);
        end
        nextChanged = 1'b1;
      end else if (!upReq && !downReq) begin
        // Left and right together cancel, mirroring up/down.
        if (left_pulse && !right_pulse) begin
          nextCursor = (cursor_out == LAST_CURSOR) ? '0 : cursor_out + 1'b1;
          nextBlink  = '0;
        end else if (right_pulse && !left_pulse) begin
          nextCursor = (cursor_out == '0) ? LAST_CURSOR : cursor_out - 1'b1;
          nextBlink  = '0;
        end
      end
    end

    nextMask = '1;
    if (nextState == ST_EDIT) begin
      for (int i = 0; i < NUM_DIGITS; i++) begin
        if (CURSOR_W'(i) == nextCursor) nextMask[i] = ~nextBlink[BLINK_DIV_W-1];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= ST_VIEW;
      digits_out    <= '0;
      cursor_out    <= '0;
      blinkCnt      <= '0;
      digit_en_mask <= '1;
      edit_mode     <= 1'b0;
      value_changed <= 1'b0;
    end else begin
      state         <= nextState;
      digits_out    <= nextDigits;
      cursor_out    <= nextCursor;
      blinkCnt      <= nextBlink;
      digit_en_mask <= nextMask;
      edit_mode     <= (nextState == ST_EDIT);
      value_changed <= nextChanged;
    end
  end

endmodule
